sccb_init_sequencer: RTL and testbench

// Autonomous camera-configuration controller: walks a table of (register, value) entries,

---
 rtl/sccb_init_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_sccb_init_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_init_sequencer.sv
// Camera bring-up sequencer: walks a (register, value) ROM table, issuing one SCCB write per
// entry with optional read-back verify, bounded retries and programmed millisecond delays.
module sccb_init_sequencer #(
    parameter int unsigned AW         = 8,
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int unsigned CLK_PER_MS = 100000,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned VERIFY     = 1
) (
    input  logic          sys_clock_i,
    input  logic          reset_i,
    input  logic          go_i,
    output logic [AW-1:0] rom_addr_o,
    input  logic [15:0]   rom_data_i,
    output logic          sccb_start_o,
    output logic [7:0]    sccb_id_o,
    output logic [7:0]    sccb_reg_o,
    output logic [7:0]    sccb_wdata_o,
    input  logic          sccb_busy_i,
    input  logic          sccb_done_i,
    input  logic          sccb_nack_i,
    input  logic [7:0]    sccb_rdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [AW-1:0] err_index_o
);

    localparam int unsigned DW = $clog2(255 * CLK_PER_MS + 1);
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [DW-1:0] ClkPerMs      = DW'(CLK_PER_MS);
    localparam logic [DW-1:0] EntryOverhead = DW'(3);
    localparam logic [RW-1:0] MaxRetry      = RW'(MAX_RETRY);
    localparam logic [7:0]    RdId          = DEV_ID | 8'h01;

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StFetch  = 4'd1;
    localparam logic [3:0] StDecode = 4'd2;
    localparam logic [3:0] StWrReq  = 4'd3;
    localparam logic [3:0] StWrWait = 4'd4;
    localparam logic [3:0] StRdReq  = 4'd5;
    localparam logic [3:0] StRdWait = 4'd6;
    localparam logic [3:0] StDelay  = 4'd7;
    localparam logic [3:0] StDone   = 4'd8;
    localparam logic [3:0] StError  = 4'd9;

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] index_q, index_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [7:0]    reg_q, reg_d;
    logic [7:0]    val_q, val_d;
    logic [7:0]    id_q, id_d;
    logic          start_q, start_d;
    logic [AW-1:0] err_index_q, err_index_d;

    logic [DW-1:0] delay_prod;
    logic [DW-1:0] delay_load;
    logic          advance;
    logic          retry_fail;

    // The fetch, decode and exit cycles are part of the wait, so an F0nn entry spans nn ms
    // measured from its own fetch to the fetch of the next entry.
    assign delay_prod = DW'(rom_data_i[7:0]) * ClkPerMs;
    assign delay_load = (delay_prod > EntryOverhead) ? (delay_prod - EntryOverhead) : '0;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        delay_d     = delay_q;
        reg_d       = reg_q;
        val_d       = val_q;
        id_d        = id_q;
        start_d     = 1'b0;
        err_index_d = err_index_q;
        advance     = 1'b0;
        retry_fail  = 1'b0;

        case (state_q)
            StIdle, StDone, StError: begin
                if (go_i) begin
                    state_d     = StFetch;
                    index_d     = '0;
                    retry_d     = '0;
                    err_index_d = '0;
                end
            end
            StFetch:  state_d = StDecode;
            StDecode: begin
                if (rom_data_i == 16'hFFFF) begin
                    state_d = StDone;
                end else if (rom_data_i[15:8] == 8'hF0) begin
                    delay_d = delay_load;
                    state_d = StDelay;
                end else begin
                    reg_d   = rom_data_i[15:8];
                    val_d   = rom_data_i[7:0];
                    state_d = StWrReq;
                end
            end
            StWrReq: begin
                if (!sccb_busy_i) begin
                    start_d = 1'b1;
                    id_d    = DEV_ID;
                    state_d = StWrWait;
                end
            end
            StWrWait: begin
                if (sccb_done_i) begin
                    if (sccb_nack_i)      retry_fail = 1'b1;
                    else if (VERIFY != 0) state_d    = StRdReq;
                    else                  advance    = 1'b1;
                end
            end
            StRdReq: begin
                if (!sccb_busy_i) begin
                    start_d = 1'b1;
                    id_d    = RdId;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (sccb_done_i) begin
                    if (sccb_nack_i || (sccb_rdata_i != val_q)) retry_fail = 1'b1;
                    else                                         advance    = 1'b1;
                end
            end
            StDelay: begin
                if (delay_q == '0) advance = 1'b1;
                else               delay_d = delay_q - DW'(1);
            end
            default: state_d = StIdle;
        endcase

        if (retry_fail) begin
            if (retry_q < MaxRetry) begin
                retry_d = retry_q + RW'(1);
                state_d = StWrReq;
            end else begin
                err_index_d = index_q;
                state_d     = StError;
            end
        end

        // Running off the end of the address space means the table had no terminator.
        if (advance) begin
            retry_d = '0;
            if (index_q == {AW{1'b1}}) begin
                err_index_d = {AW{1'b1}};
                state_d     = StError;
            end else begin
                index_d = index_q + AW'(1);
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge sys_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            index_q     <= '0;
            retry_q     <= '0;
            delay_q     <= '0;
            reg_q       <= '0;
            val_q       <= '0;
            id_q        <= '0;
            start_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            delay_q     <= delay_d;
            reg_q       <= reg_d;
            val_q       <= val_d;
            id_q        <= id_d;
            start_q     <= start_d;
            err_index_q <= err_index_d;
        end
    end

    assign rom_addr_o   = index_q;
    assign sccb_start_o = start_q;
    assign sccb_id_o    = id_q;
    assign sccb_reg_o   = reg_q;
    assign sccb_wdata_o = val_q;
    assign busy_o       = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);
    assign done_o       = (state_q == StDone);
    assign error_o      = (state_q == StError);
    assign err_index_o  = err_index_q;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// Bench for sccb_init_sequencer: a VERIFY=0 and a VERIFY=1 instance share one ROM and one
// SCCB engine model; expected transactions are queued up front and popped on each start.
module tb_sccb_init_sequencer;

    typedef struct {
        bit          verify;
        logic [63:0] words;      // {w3, w2, w1, w0}
        logic [7:0]  nack_reg;
        int          nack_times;
        logic [7:0]  bad_reg;
        bit          exp_done;
        bit          exp_error;
        logic [7:0]  exp_idx;
    } vec_t;

    typedef struct {
        logic [7:0] id;
        logic [7:0] rg;
        logic [7:0] wd;
        bit         is_wr;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic sel;
    logic go_a, go_b;
    logic [7:0] addr_a, addr_b, id_a, id_b, reg_a, reg_b, wd_a, wd_b, eidx_a, eidx_b;
    logic start_a, start_b, busy_a, busy_b, fin_a, fin_b, err_a, err_b;
    logic [15:0] rom_data;
    logic [15:0] rom_mem [256];

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_nack = 1'b0;
    logic [7:0]  m_rdata = 8'h00;
    logic        m_rd = 1'b0;
    logic [7:0]  m_reg = 8'h00;
    logic [7:0]  m_val = 8'h00;
    int          m_cnt = 0;
    int          m_attempts = 0;
    logic [7:0]  sensor [256];
    logic [7:0]  nack_reg, bad_reg;
    int          nack_times;

    logic       s_start, c_busy, c_fin, c_err;
    logic [7:0] s_id, s_reg, s_wd, c_eidx;
    logic       done_a, done_b;

    assign s_start = sel ? start_b : start_a;
    assign s_id    = sel ? id_b : id_a;
    assign s_reg   = sel ? reg_b : reg_a;
    assign s_wd    = sel ? wd_b : wd_a;
    assign c_busy  = sel ? busy_b : busy_a;
    assign c_fin   = sel ? fin_b : fin_a;
    assign c_err   = sel ? err_b : err_a;
    assign c_eidx  = sel ? eidx_b : eidx_a;
    assign done_a  = m_done & ~sel;
    assign done_b  = m_done & sel;

    sccb_init_sequencer #(.AW(8), .DEV_ID(8'h42), .CLK_PER_MS(10), .MAX_RETRY(3), .VERIFY(0))
    u_dut_nv (
        .sys_clock_i(clk), .reset_i(rst), .go_i(go_a), .rom_addr_o(addr_a),
        .rom_data_i(rom_data), .sccb_start_o(start_a), .sccb_id_o(id_a), .sccb_reg_o(reg_a),
        .sccb_wdata_o(wd_a), .sccb_busy_i(m_busy), .sccb_done_i(done_a), .sccb_nack_i(m_nack),
        .sccb_rdata_i(m_rdata), .busy_o(busy_a), .done_o(fin_a), .error_o(err_a),
        .err_index_o(eidx_a)
    );

    sccb_init_sequencer #(.AW(8), .DEV_ID(8'h42), .CLK_PER_MS(10), .MAX_RETRY(3), .VERIFY(1))
    u_dut_v (
        .sys_clock_i(clk), .reset_i(rst), .go_i(go_b), .rom_addr_o(addr_b),
        .rom_data_i(rom_data), .sccb_start_o(start_b), .sccb_id_o(id_b), .sccb_reg_o(reg_b),
        .sccb_wdata_o(wd_b), .sccb_busy_i(m_busy), .sccb_done_i(done_b), .sccb_nack_i(m_nack),
        .sccb_rdata_i(m_rdata), .busy_o(busy_b), .done_o(fin_b), .error_o(err_b),
        .err_index_o(eidx_b)
    );

    always @(posedge clk) rom_data <= rom_mem[sel ? addr_b : addr_a];

    // SCCB engine model: 4-cycle transactions, scripted NACKs on writes, corrupt reads of bad_reg.
    always @(posedge clk) begin
        m_done <= 1'b0;
        if (go_a || go_b) m_attempts <= 0;
        if (s_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 4;
            m_rd   <= s_id[0];
            m_reg  <= s_reg;
            m_val  <= s_wd;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (!m_rd && m_reg == nack_reg && m_attempts < nack_times) begin
                    m_nack     <= 1'b1;
                    m_attempts <= m_attempts + 1;
                end else begin
                    m_nack <= 1'b0;
                    if (m_rd) m_rdata <= (m_reg == bad_reg) ? ~sensor[m_reg] : sensor[m_reg];
                    else      sensor[m_reg] <= m_val;
                end
            end
        end
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   n_starts = 0;
    txn_t exp_q[$];
    txn_t mon_t;
    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (s_start === 1'b1) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                mon_t = exp_q.pop_front();
                check("start_id", {24'd0, s_id}, {24'd0, mon_t.id});
                check("start_reg", {24'd0, s_reg}, {24'd0, mon_t.rg});
                if (mon_t.is_wr) check("start_wdata", {24'd0, s_wd}, {24'd0, mon_t.wd});
            end
        end
    end

    task automatic add_vec(input bit verify, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3,
                           input logic [7:0] nr, input int nt, input logic [7:0] br,
                           input bit ed, input bit ee, input logic [7:0] ei);
        vec_t v;
        v.verify = verify; v.words = {w3, w2, w1, w0};
        v.nack_reg = nr; v.nack_times = nt; v.bad_reg = br;
        v.exp_done = ed; v.exp_error = ee; v.exp_idx = ei;
        vecs.push_back(v);
    endtask

    task automatic load_rom(input logic [63:0] words);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        for (int i = 0; i < 4; i++) rom_mem[i] = words[16*i +: 16];
    endtask

    // Independent walk of the table producing the transactions the engine should see.
    task automatic build_expected(input vec_t v);
        logic [15:0] w;
        int   nacks = 0;
        bit   ok;
        txn_t t;
        for (int i = 0; i < 4; i++) begin
            w = v.words[16*i +: 16];
            if (w == 16'hFFFF) break;
            if (w[15:8] == 8'hF0) continue;
            ok = 1'b0;
            for (int a = 0; a < 4 && !ok; a++) begin
                t.id = 8'h42; t.rg = w[15:8]; t.wd = w[7:0]; t.is_wr = 1'b1;
                exp_q.push_back(t);
                if (w[15:8] == v.nack_reg && nacks < v.nack_times) begin
                    nacks++;
                end else if (!v.verify) begin
                    ok = 1'b1;
                end else begin
                    t.id = 8'h43; t.is_wr = 1'b0;
                    exp_q.push_back(t);
                    if (w[15:8] != v.bad_reg) ok = 1'b1;
                end
            end
            if (!ok) break;
        end
    endtask

    task automatic pulse_go();
        if (sel) go_b = 1'b1; else go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0; go_b = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        bit seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk);
            if (c_fin || c_err) seen = 1'b1;
        end
        if (!seen) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_starts(input int target);
        for (int c = 0; c < 500 && n_starts < target; c++) @(negedge clk);
        check("start_count_reached", (n_starts >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    int lat;
    int base;

    initial begin
        rst = 1'b1; go_a = 1'b0; go_b = 1'b0; sel = 1'b0;
        nack_reg = 8'hEE; nack_times = 0; bad_reg = 8'hEE;
        for (int i = 0; i < 256; i++) sensor[i] = 8'h00;
        load_rom({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
        repeat (3) @(negedge clk);
        check("rst_flags", {24'd0, busy_a, fin_a, err_a, start_a, busy_b, fin_b, err_b, start_b},
              32'd0);
        check("rst_addr_eidx", {addr_a, addr_b, eidx_a, eidx_b}, 32'd0);
        check("rst_sccb_fields", {8'd0, id_a, reg_a, wd_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        add_vec(0, 16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF, 8'hEE, 0,   8'hEE, 1, 0, 8'h00);
        add_vec(1, 16'h1280, 16'h1100, 16'hFFFF, 16'hFFFF, 8'hEE, 0,   8'hEE, 1, 0, 8'h00);
        add_vec(0, 16'h1280, 16'h1100, 16'h1355, 16'hFFFF, 8'h11, 3,   8'hEE, 1, 0, 8'h00);
        add_vec(0, 16'h1280, 16'h1100, 16'h1355, 16'hFFFF, 8'h13, 255, 8'hEE, 0, 1, 8'h02);
        add_vec(1, 16'h1280, 16'h0A5A, 16'hFFFF, 16'hFFFF, 8'hEE, 0,   8'h0A, 0, 1, 8'h01);
        add_vec(0, 16'hF002, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hEE, 0,   8'hEE, 1, 0, 8'h00);
        add_vec(1, 16'hF000, 16'h2233, 16'hFFFF, 16'hFFFF, 8'hEE, 0,   8'hEE, 1, 0, 8'h00);
        add_vec(1, 16'hF000, 16'h2233, 16'h2477, 16'hFFFF, 8'h22, 2,   8'hEE, 1, 0, 8'h00);

        for (int v = 0; v < vecs.size(); v++) begin
            sel = vecs[v].verify;
            nack_reg = vecs[v].nack_reg; nack_times = vecs[v].nack_times;
            bad_reg = vecs[v].bad_reg;
            load_rom(vecs[v].words);
            exp_q.delete();
            build_expected(vecs[v]);
            pulse_go();
            wait_end("vec_end");
            check("vec_done", {31'd0, c_fin}, {31'd0, vecs[v].exp_done});
            check("vec_error", {31'd0, c_err}, {31'd0, vecs[v].exp_error});
            if (vecs[v].exp_error) check("vec_err_index", {24'd0, c_eidx}, {24'd0, vecs[v].exp_idx});
            repeat (20) @(negedge clk);
            check("vec_txns_left", exp_q.size(), 32'd0);
            check("vec_busy_after", {31'd0, c_busy}, 32'd0);
        end

        // Delay-only table: done about 20 cycles after go, no transactions.
        sel = 1'b0; nack_reg = 8'hEE; nack_times = 0; bad_reg = 8'hEE;
        load_rom({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hF002});
        exp_q.delete();
        go_a = 1'b1;
        @(negedge clk);
        go_a = 1'b0;
        lat = 0;
        while (!c_fin && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("delay_latency_in_window", (lat >= 17 && lat <= 23) ? 32'd1 : 32'd0, 32'd1);

        // go while busy in entry 1's write must not restart the table.
        load_rom({16'hFFFF, 16'hFFFF, 16'h1100, 16'h1280});
        exp_q.delete();
        build_expected(vecs[0]);
        base = n_starts;
        pulse_go();
        wait_starts(base + 2);
        pulse_go();
        wait_end("busy_go_end");
        check("busy_go_done", {31'd0, c_fin}, 32'd1);
        repeat (10) @(negedge clk);
        check("busy_go_txns_left", exp_q.size(), 32'd0);

        // Reset in the first write's wait; go pulsed during reset is ignored.
        exp_q.delete();
        build_expected(vecs[0]);
        base = n_starts;
        pulse_go();
        wait_starts(base + 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_flags", {28'd0, busy_a, fin_a, err_a, start_a}, 32'd0);
        check("midrst_addr", {24'd0, addr_a}, 32'd0);
        @(negedge clk);
        pulse_go();
        rst = 1'b0;
        exp_q.delete();
        base = n_starts;
        repeat (30) @(negedge clk);
        check("midrst_idle", {30'd0, busy_a, fin_a}, 32'd0);
        check("midrst_no_start", n_starts - base, 32'd0);
        build_expected(vecs[0]);
        pulse_go();
        wait_end("restart_end");
        check("restart_done", {31'd0, fin_a}, 32'd1);
        repeat (10) @(negedge clk);
        check("restart_txns_left", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
